// File: rtl/rv_predecode_pipe_pkg.sv
// Shared opcode map, immediate format codes and skid-buffer states for the predecode stage.
package rv_predecode_pipe_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/rv_predecode_pipe_imm_decode.sv
// Combinational decode of instruction format, sign-extended immediate and illegal-opcode flag.
module rv_predecode_pipe_imm_decode
  import rv_predecode_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CHECK_ILL = 1
) (
  input  logic [31:0]     ir,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    logic signed [XLEN-1:0] r;
    r = XLEN'(v);
    return r;
  endfunction

  fmt_e fmt_v;
  logic known;

  always_comb begin
    fmt_v = FMT_NONE;
    known = 1'b1;
    // Compressed/reserved encodings (ir[1:0] != 2'b11) carry no format at all.
    if (ir[1:0] != 2'b11) begin
      known = 1'b0;
    end else begin
      case (ir[6:2])
        OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt_v = FMT_I;
        OPC_STORE:                                  fmt_v = FMT_S;
        OPC_BRANCH:                                 fmt_v = FMT_B;
        OPC_LUI, OPC_AUIPC:                         fmt_v = FMT_U;
        OPC_JAL:                                    fmt_v = FMT_J;
        OPC_OP, OPC_MISC_MEM:                       fmt_v = FMT_NONE;
        default:                                    known = 1'b0;
      endcase
    end
  end

  always_comb begin
    imm = '0;
    case (fmt_v)
      FMT_I: imm = sext32({{20{ir[31]}}, ir[31:20]});
      FMT_S: imm = sext32({{20{ir[31]}}, ir[31:25], ir[11:7]});
      FMT_B: imm = sext32({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
      FMT_U: imm = sext32({ir[31:12], 12'h000});
      FMT_J: imm = sext32({{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
      default: imm = '0;
    endcase
  end

  assign fmt     = fmt_v;
  assign illegal = (CHECK_ILL != 0) && !known;

endmodule

// File: rtl/rv_predecode_pipe.sv
// Two-entry skid-buffered predecode stage: main reg M drives execute, skid reg S absorbs back-pressure.
module rv_predecode_pipe
  import rv_predecode_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CHECK_ILL = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     f_valid_i,
  output logic                     f_ready_o,
  input  logic [31:0]              f_ir_i,
  input  logic [XLEN-1:0]          f_pc_i,
  input  logic                     x_kill_i,
  output logic                     x_valid_o,
  input  logic                     x_ready_i,
  output logic [XLEN-1:0]          x_pc_o,
  output logic [31:0]              x_ir_o,
  output logic [4:0]               rf_rs1_o,
  output logic [4:0]               rf_rs2_o,
  output logic [4:0]               x_rs1_o,
  output logic [4:0]               x_rs2_o,
  output logic [4:0]               x_rd_o,
  output logic [4:0]               x_opcode_o,
  output logic [2:0]               x_fun_o,
  output logic [$clog2(XLEN)-1:0]  x_shamt_o,
  output logic                     x_shifter_sign_o,
  output logic [2:0]               x_fmt_o,
  output logic [XLEN-1:0]          x_imm_o,
  output logic                     x_illegal_o
);

  state_e          state_p1, state_d;
  logic [31:0]     m_ir_p1, s_ir_p1;
  logic [XLEN-1:0] m_pc_p1, s_pc_p1;
  logic            accept, consume, ld_m_in, ld_m_s, ld_s, use_s;
  logic            dec_illegal;

  assign f_ready_o = (state_p1 != ST_TWO) && !rst_i;
  assign x_valid_o = (state_p1 != ST_EMPTY);
  assign accept    = f_valid_i & f_ready_o;
  assign consume   = x_valid_o & x_ready_i;

  always_comb begin
    state_d = state_p1;
    ld_m_in = 1'b0;
    ld_m_s  = 1'b0;
    ld_s    = 1'b0;
    case (state_p1)
      ST_EMPTY: if (accept) begin
        state_d = ST_ONE;
        ld_m_in = 1'b1;
      end
      ST_ONE: begin
        if (accept && consume) begin
          ld_m_in = 1'b1;
        end else if (accept) begin
          state_d = ST_TWO;
          ld_s    = 1'b1;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: if (consume) begin
        state_d = ST_ONE;
        ld_m_s  = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
    // Kill overrides everything, including a same-cycle accept.
    if (x_kill_i) begin
      state_d = ST_EMPTY;
      ld_m_in = 1'b0;
      ld_m_s  = 1'b0;
      ld_s    = 1'b0;
    end
  end

  // ---- stage p1: M/S storage ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p1 <= ST_EMPTY;
      m_ir_p1  <= '0;
      m_pc_p1  <= '0;
      s_ir_p1  <= '0;
      s_pc_p1  <= '0;
    end else begin
      state_p1 <= state_d;
      if (ld_m_in) begin
        m_ir_p1 <= f_ir_i;
        m_pc_p1 <= f_pc_i;
      end else if (ld_m_s) begin
        m_ir_p1 <= s_ir_p1;
        m_pc_p1 <= s_pc_p1;
      end
      if (ld_s) begin
        s_ir_p1 <= f_ir_i;
        s_pc_p1 <= f_pc_i;
      end
    end
  end

  // Register-file read address for whatever lands in M next cycle.
  assign use_s    = (state_p1 == ST_TWO) && consume && !x_kill_i;
  assign rf_rs1_o = use_s ? s_ir_p1[19:15] : f_ir_i[19:15];
  assign rf_rs2_o = use_s ? s_ir_p1[24:20] : f_ir_i[24:20];

  assign x_pc_o           = m_pc_p1;
  assign x_ir_o           = m_ir_p1;
  assign x_rs1_o          = m_ir_p1[19:15];
  assign x_rs2_o          = m_ir_p1[24:20];
  assign x_rd_o           = m_ir_p1[11:7];
  assign x_opcode_o       = m_ir_p1[6:2];
  assign x_fun_o          = m_ir_p1[14:12];
  assign x_shifter_sign_o = m_ir_p1[30];

  generate
    if (XLEN == 64) begin : g_shamt64
      assign x_shamt_o = m_ir_p1[25:20];
    end else begin : g_shamt32
      assign x_shamt_o = m_ir_p1[24:20];
    end
  endgenerate

  rv_predecode_pipe_imm_decode #(
    .XLEN      (XLEN),
    .CHECK_ILL (CHECK_ILL)
  ) u_imm_decode (
    .ir      (m_ir_p1),
    .fmt     (x_fmt_o),
    .imm     (x_imm_o),
    .illegal (dec_illegal)
  );

  assign x_illegal_o = x_valid_o & dec_illegal;

endmodule

// File: tb/tb_rv_predecode_pipe.sv
// Directed bench: three instances (XLEN=32, XLEN=64, CHECK_ILL=0) share one stimulus stream.
module tb_rv_predecode_pipe;

  logic        clk = 1'b0;
  logic        rst, f_valid, kill, x_ready;
  logic [31:0] f_ir;
  logic [63:0] f_pc;

  logic        f_ready, x_valid, sgn, ill;
  logic [31:0] x_pc, x_ir, imm;
  logic [4:0]  rf_rs1, rf_rs2, rs1, rs2, rd, opcode, shamt;
  logic [2:0]  fun, fmt;

  logic        f_ready_w, x_valid_w, sgn_w, ill_w;
  logic [63:0] x_pc_w, imm_w;
  logic [31:0] x_ir_w;
  logic [4:0]  rf_rs1_w, rf_rs2_w, rs1_w, rs2_w, rd_w, opcode_w;
  logic [5:0]  shamt_w;
  logic [2:0]  fun_w, fmt_w;

  logic        f_ready_n, x_valid_n, sgn_n, ill_n;
  logic [31:0] x_pc_n, x_ir_n, imm_n;
  logic [4:0]  rf_rs1_n, rf_rs2_n, rs1_n, rs2_n, rd_n, opcode_n, shamt_n;
  logic [2:0]  fun_n, fmt_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_predecode_pipe #(.XLEN(32), .CHECK_ILL(1)) dut (
    .clk_i(clk), .rst_i(rst), .f_valid_i(f_valid), .f_ready_o(f_ready), .f_ir_i(f_ir),
    .f_pc_i(f_pc[31:0]), .x_kill_i(kill), .x_valid_o(x_valid), .x_ready_i(x_ready),
    .x_pc_o(x_pc), .x_ir_o(x_ir), .rf_rs1_o(rf_rs1), .rf_rs2_o(rf_rs2), .x_rs1_o(rs1),
    .x_rs2_o(rs2), .x_rd_o(rd), .x_opcode_o(opcode), .x_fun_o(fun), .x_shamt_o(shamt),
    .x_shifter_sign_o(sgn), .x_fmt_o(fmt), .x_imm_o(imm), .x_illegal_o(ill));

  rv_predecode_pipe #(.XLEN(64), .CHECK_ILL(1)) dut64 (
    .clk_i(clk), .rst_i(rst), .f_valid_i(f_valid), .f_ready_o(f_ready_w), .f_ir_i(f_ir),
    .f_pc_i(f_pc), .x_kill_i(kill), .x_valid_o(x_valid_w), .x_ready_i(x_ready),
    .x_pc_o(x_pc_w), .x_ir_o(x_ir_w), .rf_rs1_o(rf_rs1_w), .rf_rs2_o(rf_rs2_w), .x_rs1_o(rs1_w),
    .x_rs2_o(rs2_w), .x_rd_o(rd_w), .x_opcode_o(opcode_w), .x_fun_o(fun_w), .x_shamt_o(shamt_w),
    .x_shifter_sign_o(sgn_w), .x_fmt_o(fmt_w), .x_imm_o(imm_w), .x_illegal_o(ill_w));

  rv_predecode_pipe #(.XLEN(32), .CHECK_ILL(0)) dutn (
    .clk_i(clk), .rst_i(rst), .f_valid_i(f_valid), .f_ready_o(f_ready_n), .f_ir_i(f_ir),
    .f_pc_i(f_pc[31:0]), .x_kill_i(kill), .x_valid_o(x_valid_n), .x_ready_i(x_ready),
    .x_pc_o(x_pc_n), .x_ir_o(x_ir_n), .rf_rs1_o(rf_rs1_n), .rf_rs2_o(rf_rs2_n), .x_rs1_o(rs1_n),
    .x_rs2_o(rs2_n), .x_rd_o(rd_n), .x_opcode_o(opcode_n), .x_fun_o(fun_n), .x_shamt_o(shamt_n),
    .x_shifter_sign_o(sgn_n), .x_fmt_o(fmt_n), .x_imm_o(imm_n), .x_illegal_o(ill_n));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; f_valid = 1'b0; kill = 1'b0; x_ready = 1'b0;
    f_ir = 32'h0; f_pc = 64'h0;
    tick(); tick();
    chk("rst_ready", 64'(f_ready), 64'd0);
    chk("rst_valid", 64'(x_valid), 64'd0);
    chk("rst_ir", 64'(x_ir), 64'd0);
    chk("rst_pc", 64'(x_pc), 64'd0);
    chk("rst_fmt", 64'(fmt), 64'd0);
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_ill", 64'(ill), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 64'(f_ready), 64'd1);
    chk("post_rst_valid", 64'(x_valid), 64'd0);

    // ADDI x1,x0,-1 streamed with execute ready.
    x_ready = 1'b1; f_valid = 1'b1; f_ir = 32'hFFF00093; f_pc = 64'h100;
    tick();
    chk("addi_valid", 64'(x_valid), 64'd1);
    chk("addi_fmt", 64'(fmt), 64'd1);
    chk("addi_imm", 64'(imm), 64'h00000000_FFFFFFFF);
    chk("addi_imm64", imm_w, 64'hFFFFFFFF_FFFFFFFF);
    chk("addi_rd", 64'(rd), 64'd1);
    chk("addi_pc", 64'(x_pc), 64'h100);
    chk("addi_opc", 64'(opcode), 64'h04);
    chk("addi_ill", 64'(ill), 64'd0);
    f_valid = 1'b0;
    tick();
    chk("addi_drain", 64'(x_valid), 64'd0);

    // Back-pressure: BEQ, JAL, LUI pushed while execute stalls.
    x_ready = 1'b0; f_valid = 1'b1; f_ir = 32'hFE000EE3; f_pc = 64'h200;
    tick();
    chk("bp1_ready", 64'(f_ready), 64'd1);
    f_ir = 32'h0040006F; f_pc = 64'h204;
    tick();
    chk("bp2_ready", 64'(f_ready), 64'd0);
    chk("bp2_ir", 64'(x_ir), 64'hFE000EE3);
    chk("beq_fmt", 64'(fmt), 64'd3);
    chk("beq_imm", 64'(imm), 64'h00000000_FFFFFFFC);
    f_ir = 32'h12345037; f_pc = 64'h208;
    tick();
    chk("bp3_ready", 64'(f_ready), 64'd0);
    chk("bp3_stable_ir", 64'(x_ir), 64'hFE000EE3);
    chk("bp3_stable_pc", 64'(x_pc), 64'h200);
    x_ready = 1'b1;
    #1;
    chk("rf_rs2_from_s", 64'(rf_rs2), 64'd4);
    tick();
    chk("jal_ir", 64'(x_ir), 64'h0040006F);
    chk("jal_fmt", 64'(fmt), 64'd5);
    chk("jal_imm", 64'(imm), 64'd4);
    chk("jal_ready", 64'(f_ready), 64'd1);
    tick();
    chk("lui_ir", 64'(x_ir), 64'h12345037);
    chk("lui_fmt", 64'(fmt), 64'd4);
    chk("lui_imm", 64'(imm), 64'h12345000);
    chk("lui_pc", 64'(x_pc), 64'h208);
    f_valid = 1'b0;
    tick();
    chk("bp_no_dup", 64'(x_valid), 64'd0);

    // XLEN=64: SRAI shamt 63 and LUI with negative upper immediate.
    f_valid = 1'b1; f_ir = 32'h43F05093; f_pc = 64'h300;
    #1;
    chk("rf_rs1_from_in", 64'(rf_rs1), 64'd0);
    tick();
    chk("srai_shamt64", 64'(shamt_w), 64'd63);
    chk("srai_sign64", 64'(sgn_w), 64'd1);
    chk("srai_shamt32", 64'(shamt), 64'd31);
    f_ir = 32'h80000037;
    tick();
    chk("lui64_imm", imm_w, 64'hFFFFFFFF_80000000);
    chk("lui32_imm", 64'(imm), 64'h00000000_80000000);
    f_valid = 1'b0;
    tick();

    // Kill in state TWO with fetch still presenting.
    x_ready = 1'b0; f_valid = 1'b1; f_ir = 32'hFFF00093; f_pc = 64'h400;
    tick();
    f_ir = 32'h0040006F;
    tick();
    chk("kill_pre_ready", 64'(f_ready), 64'd0);
    kill = 1'b1; f_ir = 32'h12345037;
    tick();
    chk("kill2_valid", 64'(x_valid), 64'd0);
    chk("kill2_ready", 64'(f_ready), 64'd1);
    kill = 1'b0; f_valid = 1'b0;
    tick();
    chk("kill2_dropped", 64'(x_valid), 64'd0);

    // Kill in state ONE together with an accept: the accept is dropped.
    f_valid = 1'b1; f_ir = 32'hFFF00093;
    tick();
    chk("kill1_pre_valid", 64'(x_valid), 64'd1);
    kill = 1'b1; f_ir = 32'h0040006F;
    tick();
    chk("kill1_valid", 64'(x_valid), 64'd0);
    kill = 1'b0; f_valid = 1'b0;
    tick();
    chk("kill1_dropped", 64'(x_valid), 64'd0);

    // Illegal encodings, with and without checking.
    x_ready = 1'b1; f_valid = 1'b1; f_ir = 32'h00000000;
    tick();
    chk("ill0_flag", 64'(ill), 64'd1);
    chk("ill0_fmt", 64'(fmt), 64'd0);
    chk("ill0_imm", 64'(imm), 64'd0);
    chk("ill0_nochk", 64'(ill_n), 64'd0);
    f_ir = 32'h0000000B;
    tick();
    chk("ill0b_flag", 64'(ill), 64'd1);
    chk("ill0b_fmt", 64'(fmt), 64'd0);
    chk("ill0b_nochk", 64'(ill_n), 64'd0);
    f_valid = 1'b0;
    tick();

    // Reset mid-operation discards buffered instructions.
    x_ready = 1'b0; f_valid = 1'b1; f_ir = 32'hFE000EE3;
    tick();
    rst = 1'b1; f_valid = 1'b0;
    tick();
    chk("mrst_valid", 64'(x_valid), 64'd0);
    chk("mrst_ready", 64'(f_ready), 64'd0);
    chk("mrst_ir", 64'(x_ir), 64'd0);
    rst = 1'b0;
    tick();
    chk("mrst_after_ready", 64'(f_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
